multicycle_control_unit: RTL

Multi-cycle LEGv8 control unit: a state machine that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath control lines per state, and it stalls on a memory ready handshake. It replaces the single-cycle combinational decoder in the datapath. It adds a memory-timeout error trap and an illegal-opcode flag, and it parametrises the opcode and ALU-operation widths.

---
 rtl/cu_pkg.sv | 46 ++++
 rtl/cu_decode.sv | 38 +++
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
// Optional feature macro: CU_UNCOND_BRANCH_EN (B opcode class).
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_R,
    CL_LDUR,
    CL_STUR,
    CL_CBZ,
    CL_B,
    CL_ILL
  } cls_e;

  // Decode patterns are matched against the top 11 opcode bits
  localparam logic [10:0] OPC_R_MSK   = 11'b10011110111;
  localparam logic [10:0] OPC_R_VAL   = 11'b10001010000;
  localparam logic [10:0] OPC_LDUR    = 11'b11111000010;
  localparam logic [10:0] OPC_STUR    = 11'b11111000000;
  localparam logic [10:0] OPC_CBZ_MSK = 11'b11111111000;
  localparam logic [10:0] OPC_CBZ_VAL = 11'b10110100000;
  localparam logic [10:0] OPC_B_MSK   = 11'b11111100000;
  localparam logic [10:0] OPC_B_VAL   = 11'b00010100000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic op_match(
    input logic [10:0] op,
    input logic [10:0] msk,
    input logic [10:0] val
  );
    return (op & msk) == val;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-class classifier.
// Optional feature macro: CU_UNCOND_BRANCH_EN (B opcode class).
module cu_decode
  import cu_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [OP_W-1:0] i_op,
  output cls_e            o_cls
);

  logic [10:0] w_top;

  assign w_top = i_op[OP_W-1 -: 11];

  always_comb begin
    o_cls = CL_ILL;
    unique case (1'b1)
      (i_op == '0):
        o_cls = CL_NOP;
      op_match(w_top, OPC_R_MSK, OPC_R_VAL):
        o_cls = CL_R;
      (w_top == OPC_LDUR):
        o_cls = CL_LDUR;
      (w_top == OPC_STUR):
        o_cls = CL_STUR;
      op_match(w_top, OPC_CBZ_MSK, OPC_CBZ_VAL):
        o_cls = CL_CBZ;
`ifdef CU_UNCOND_BRANCH_EN
      op_match(w_top, OPC_B_MSK, OPC_B_VAL):
        o_cls = CL_B;
`endif
      default:
        o_cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 control FSM with memory-timeout trap.
// Optional feature macro: CU_UNCOND_BRANCH_EN (B opcode class).
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OP_W    = 11,
  parameter int ALUOP_W = 2,
  parameter int TMO_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Operation,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               Reg2Loc,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOperation,
  output logic [2:0]         state_o,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_err
);

  localparam logic [7:0] TMO_M1 = 8'(TMO_CYC - 1);

  state_e     r_state;
  state_e     w_next;
  cls_e       r_cls;
  cls_e       w_cls;
  logic [7:0] r_cnt;
  logic       r_ill;
  logic       r_err;
  logic       w_wait_st;
  logic       w_tmo;
  logic       w_dec_end;

  logic       w_pcw, w_irw, w_r2l, w_asrc, w_m2r;
  logic       w_rw, w_mr, w_mw, w_br, w_done;
  logic [1:0] w_alu;

  cu_decode #(.OP_W(OP_W)) u_dec (
    .i_op  (Operation),
    .o_cls (w_cls)
  );

  assign w_wait_st = (r_state == ST_FETCH) ||
                     (r_state == ST_MEM);
  // The wait that would push the counter to TMO_CYC traps
  assign w_tmo     = w_wait_st && !mem_ready &&
                     (r_cnt == TMO_M1);
  assign w_dec_end = (w_cls == CL_NOP) ||
                     (w_cls == CL_ILL);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH: begin
        if (mem_ready)  w_next = ST_DECODE;
        else if (w_tmo) w_next = ST_ERROR;
      end
      ST_DECODE:
        w_next = w_dec_end ? ST_FETCH : ST_EXEC;
      ST_EXEC: begin
        case (r_cls)
          CL_R:    w_next = ST_WB;
          CL_LDUR: w_next = ST_MEM;
          CL_STUR: w_next = ST_MEM;
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready)
          w_next = (r_cls == CL_LDUR) ? ST_WB
                                      : ST_FETCH;
        else if (w_tmo)
          w_next = ST_ERROR;
      end
      ST_WB:   w_next = ST_FETCH;
      default: w_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_cls   <= CL_NOP;
      r_cnt   <= '0;
      r_ill   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE)
        r_cls <= w_cls;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_wait_st && !mem_ready)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == ST_DECODE && w_cls == CL_ILL)
        r_ill <= 1'b1;
      if (w_next == ST_ERROR)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_pcw  = 1'b0;
    w_irw  = 1'b0;
    w_r2l  = 1'b0;
    w_asrc = 1'b0;
    w_m2r  = 1'b0;
    w_rw   = 1'b0;
    w_mr   = 1'b0;
    w_mw   = 1'b0;
    w_br   = 1'b0;
    w_done = 1'b0;
    w_alu  = ALU_ADD;
    unique case (r_state)
      ST_FETCH: begin
        w_mr = 1'b1;
        if (mem_ready) begin
          w_irw = 1'b1;
          w_pcw = 1'b1;
        end
      end
      ST_DECODE:
        w_done = w_dec_end;
      ST_EXEC: begin
        case (r_cls)
          CL_R:    w_alu = ALU_FUNCT;
          CL_LDUR: w_asrc = 1'b1;
          CL_STUR: begin
            w_asrc = 1'b1;
            w_r2l  = 1'b1;
          end
          CL_CBZ: begin
            w_r2l  = 1'b1;
            w_alu  = ALU_PASSB;
            w_br   = zero;
            w_pcw  = zero;
            w_done = 1'b1;
          end
          CL_B: begin
            w_br   = 1'b1;
            w_pcw  = 1'b1;
            w_done = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_asrc = 1'b1;
        if (r_cls == CL_STUR) begin
          w_r2l  = 1'b1;
          w_mw   = 1'b1;
          w_done = mem_ready;
        end else begin
          w_mr = 1'b1;
        end
      end
      ST_WB: begin
        w_rw   = 1'b1;
        w_m2r  = (r_cls == CL_LDUR);
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every output low, including FETCH's MemRead
  assign PCWrite      = rst_n & w_pcw;
  assign IRWrite      = rst_n & w_irw;
  assign Reg2Loc      = rst_n & w_r2l;
  assign ALUSrc       = rst_n & w_asrc;
  assign MemtoReg     = rst_n & w_m2r;
  assign RegWrite     = rst_n & w_rw;
  assign MemRead      = rst_n & w_mr;
  assign MemWrite     = rst_n & w_mw;
  assign Branch       = rst_n & w_br;
  assign instr_done   = rst_n & w_done;
  assign ALUOperation = rst_n ? ALUOP_W'(w_alu) : '0;
  assign state_o      = rst_n ? r_state : 3'd0;
  assign illegal_op   = rst_n & r_ill;
  assign mem_err      = rst_n & r_err;

endmodule
